// File: rtl/hmmm_control_if.sv
// Control-unit bus bundle: run/instruction/flag inputs and the datapath strobes.
// The master modport is the controller side, the slave modport the datapath side.
interface hmmm_control_if;
   localparam int unsigned INSTR_W = 16;
   localparam int unsigned SEL_W   = 4;

   logic               run;
   logic [INSTR_W-1:0] instr;
   logic               rx_zero;
   logic               rx_neg;

   logic               pc_out;
   logic               ram_out;
   logic               ir_out;
   logic               rf_out;
   logic               alu_out;
   logic               mar_in;
   logic               ir_in;
   logic               pc_in;
   logic               pc_inc;
   logic               rf_in;
   logic               ram_in;
   logic [SEL_W-1:0]   rf_sel;
   logic [SEL_W-1:0]   alu_op;
   logic               halted;
   logic               illegal;

   modport master (
      input  run, instr, rx_zero, rx_neg,
      output pc_out, ram_out, ir_out, rf_out, alu_out,
      output mar_in, ir_in, pc_in, pc_inc, rf_in, ram_in,
      output rf_sel, alu_op, halted, illegal
   );

   modport slave (
      output run, instr, rx_zero, rx_neg,
      input  pc_out, ram_out, ir_out, rf_out, alu_out,
      input  mar_in, ir_in, pc_in, pc_inc, rf_in, ram_in,
      input  rf_sel, alu_op, halted, illegal
   );
endinterface

// File: rtl/hmmm_control.sv
// Moore control unit for the Hmmm datapath. Every output is registered: the
// strobes for a state are loaded on the edge that enters that state.
module hmmm_control (
   input  logic           clk,
   input  logic           rst,
   hmmm_control_if.master bus
);
   localparam int unsigned OPC_W = 4;

   typedef enum logic [2:0] {
      IDLE, FETCH_A, FETCH_B, DECODE, EXEC_A, EXEC_B, HALT
   } state_t;

   state_t           state;
   logic [OPC_W-1:0] opc;
   logic [OPC_W-1:0] rx;
   logic             is_halt;
   logic             unsupported;
   logic             jump_taken;
   logic             two_phase;

   assign opc       = bus.instr[15:12];
   assign rx        = bus.instr[11:8];
   assign is_halt   = (opc == OPC_W'(0)) && (bus.instr[7:0] == 8'h00);
   assign two_phase = (opc == OPC_W'(2)) || (opc == OPC_W'(3));

   // Encodings the datapath cannot execute
   always_comb begin
      unsupported = 1'b0;
      case (opc)
         4'h0:    unsupported = (bus.instr[7:0] != 8'h00) && (bus.instr[7:0] != 8'h03);
         4'h4:    unsupported = 1'b1;
         4'hB:    unsupported = (rx != OPC_W'(0));
         default: unsupported = 1'b0;
      endcase
   end

   // Conditional-jump predicate from the register-file flags
   always_comb begin
      jump_taken = 1'b1;
      case (opc)
         4'hC:    jump_taken = bus.rx_zero;
         4'hD:    jump_taken = !bus.rx_zero;
         4'hE:    jump_taken = !bus.rx_zero && !bus.rx_neg;
         4'hF:    jump_taken = bus.rx_neg;
         default: jump_taken = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state       <= IDLE;
         bus.pc_out  <= 1'b0;
         bus.ram_out <= 1'b0;
         bus.ir_out  <= 1'b0;
         bus.rf_out  <= 1'b0;
         bus.alu_out <= 1'b0;
         bus.mar_in  <= 1'b0;
         bus.ir_in   <= 1'b0;
         bus.pc_in   <= 1'b0;
         bus.pc_inc  <= 1'b0;
         bus.rf_in   <= 1'b0;
         bus.ram_in  <= 1'b0;
         bus.rf_sel  <= '0;
         bus.alu_op  <= '0;
         bus.halted  <= 1'b0;
         bus.illegal <= 1'b0;
      end else begin
         // Strobes are single-cycle; halted/illegal hold until reset
         bus.pc_out  <= 1'b0;
         bus.ram_out <= 1'b0;
         bus.ir_out  <= 1'b0;
         bus.rf_out  <= 1'b0;
         bus.alu_out <= 1'b0;
         bus.mar_in  <= 1'b0;
         bus.ir_in   <= 1'b0;
         bus.pc_in   <= 1'b0;
         bus.pc_inc  <= 1'b0;
         bus.rf_in   <= 1'b0;
         bus.ram_in  <= 1'b0;
         bus.rf_sel  <= '0;
         bus.alu_op  <= '0;

         case (state)
            IDLE: begin
               if (bus.run) begin
                  state      <= FETCH_A;
                  bus.pc_out <= 1'b1;
                  bus.mar_in <= 1'b1;
               end
            end
            FETCH_A: begin
               state       <= FETCH_B;
               bus.ram_out <= 1'b1;
               bus.ir_in   <= 1'b1;
               bus.pc_inc  <= 1'b1;
            end
            FETCH_B: state <= DECODE;
            DECODE: begin
               if (is_halt) begin
                  state      <= HALT;
                  bus.halted <= 1'b1;
               end else if (unsupported) begin
                  state       <= HALT;
                  bus.halted  <= 1'b1;
                  bus.illegal <= 1'b1;
               end else begin
                  state      <= EXEC_A;
                  bus.rf_sel <= rx;
                  case (opc)
                     4'h0: begin
                        bus.rf_out <= 1'b1;
                        bus.pc_in  <= 1'b1;
                     end
                     4'h1: begin
                        bus.ir_out <= 1'b1;
                        bus.rf_in  <= 1'b1;
                     end
                     4'h2, 4'h3: begin
                        bus.ir_out <= 1'b1;
                        bus.mar_in <= 1'b1;
                     end
                     4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hA: begin
                        bus.alu_out <= 1'b1;
                        bus.rf_in   <= 1'b1;
                        bus.alu_op  <= opc;
                     end
                     default: begin
                        bus.ir_out <= jump_taken;
                        bus.pc_in  <= jump_taken;
                     end
                  endcase
               end
            end
            EXEC_A: begin
               if (two_phase) begin
                  state      <= EXEC_B;
                  bus.rf_sel <= rx;
                  if (opc == OPC_W'(2)) begin
                     bus.ram_out <= 1'b1;
                     bus.rf_in   <= 1'b1;
                  end else begin
                     bus.rf_out <= 1'b1;
                     bus.ram_in <= 1'b1;
                  end
               end else begin
                  state      <= FETCH_A;
                  bus.pc_out <= 1'b1;
                  bus.mar_in <= 1'b1;
               end
            end
            EXEC_B: begin
               state      <= FETCH_A;
               bus.pc_out <= 1'b1;
               bus.mar_in <= 1'b1;
            end
            HALT:    state <= HALT;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_hmmm_control.sv
// Directed bench for hmmm_control: walks fetch/decode/execute sequences and
// compares every registered output against hand-computed vectors.
module tb_hmmm_control;
   localparam logic [10:0] PC_OUT  = 11'b100_0000_0000;
   localparam logic [10:0] RAM_OUT = 11'b010_0000_0000;
   localparam logic [10:0] IR_OUT  = 11'b001_0000_0000;
   localparam logic [10:0] RF_OUT  = 11'b000_1000_0000;
   localparam logic [10:0] ALU_OUT = 11'b000_0100_0000;
   localparam logic [10:0] MAR_IN  = 11'b000_0010_0000;
   localparam logic [10:0] IR_IN   = 11'b000_0001_0000;
   localparam logic [10:0] PC_IN   = 11'b000_0000_1000;
   localparam logic [10:0] PC_INC  = 11'b000_0000_0100;
   localparam logic [10:0] RF_IN   = 11'b000_0000_0010;
   localparam logic [10:0] RAM_IN  = 11'b000_0000_0001;
   localparam logic [10:0] NONE    = 11'b000_0000_0000;

   logic clk = 1'b0;
   logic rst;
   int   checks   = 0;
   int   failures = 0;
   logic [20:0] observed;

   always #5 clk = ~clk;

   hmmm_control_if bus ();

   hmmm_control dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.master)
   );

   assign observed = {bus.pc_out, bus.ram_out, bus.ir_out, bus.rf_out, bus.alu_out,
                      bus.mar_in, bus.ir_in, bus.pc_in, bus.pc_inc, bus.rf_in, bus.ram_in,
                      bus.rf_sel, bus.alu_op, bus.halted, bus.illegal};

   function automatic logic [20:0] mk(input logic [10:0] s, input logic [3:0] sel,
                                      input logic [3:0] op, input logic h, input logic il);
      return {s, sel, op, h, il};
   endfunction

   task automatic check(input string tag, input logic [20:0] expv);
      checks++;
      assert (observed === expv) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, observed, expv);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // From FETCH_A: one single-EXEC instruction, back to FETCH_A
   task automatic exec1(input string tag, input logic [15:0] ins, input logic [20:0] exp_a);
      bus.instr = ins;
      step(); check({tag, "_fetch_b"}, mk(RAM_OUT | IR_IN | PC_INC, 4'h0, 4'h0, 1'b0, 1'b0));
      step(); check({tag, "_decode"}, mk(NONE, 4'h0, 4'h0, 1'b0, 1'b0));
      step(); check({tag, "_exec_a"}, exp_a);
      step(); check({tag, "_fetch_a"}, mk(PC_OUT | MAR_IN, 4'h0, 4'h0, 1'b0, 1'b0));
   endtask

   // At most one bus driver in any cycle
   always @(negedge clk) begin
      checks++;
      assert ($countones({bus.pc_out, bus.ram_out, bus.ir_out, bus.rf_out, bus.alu_out}) <= 1)
      else begin
         failures++;
         $error("FAIL bus_onehot observed=%b expected=at_most_one",
                {bus.pc_out, bus.ram_out, bus.ir_out, bus.rf_out, bus.alu_out});
      end
   end

   initial begin
      rst = 1'b0;
      bus.run = 1'b0;
      bus.instr = 16'h0000;
      bus.rx_zero = 1'b0;
      bus.rx_neg = 1'b0;
      step();
      step();
      check("reset", mk(NONE, 4'h0, 4'h0, 1'b0, 1'b0));

      // setn r5: full first pass from IDLE
      rst = 1'b1;
      bus.instr = 16'h152A;
      bus.run = 1'b1;
      step(); check("setn_fetch_a", mk(PC_OUT | MAR_IN, 4'h0, 4'h0, 1'b0, 1'b0));
      bus.run = 1'b0;
      step(); check("setn_fetch_b", mk(RAM_OUT | IR_IN | PC_INC, 4'h0, 4'h0, 1'b0, 1'b0));
      step(); check("setn_decode", mk(NONE, 4'h0, 4'h0, 1'b0, 1'b0));
      step(); check("setn_exec_a", mk(IR_OUT | RF_IN, 4'h5, 4'h0, 1'b0, 1'b0));
      step(); check("setn_fetch_a2", mk(PC_OUT | MAR_IN, 4'h0, 4'h0, 1'b0, 1'b0));

      // storen r2: five-cycle loop
      bus.instr = 16'h3203;
      step(); check("storen_fetch_b", mk(RAM_OUT | IR_IN | PC_INC, 4'h0, 4'h0, 1'b0, 1'b0));
      step(); check("storen_decode", mk(NONE, 4'h0, 4'h0, 1'b0, 1'b0));
      step(); check("storen_exec_a", mk(IR_OUT | MAR_IN, 4'h2, 4'h0, 1'b0, 1'b0));
      step(); check("storen_exec_b", mk(RF_OUT | RAM_IN, 4'h2, 4'h0, 1'b0, 1'b0));
      step(); check("storen_fetch_a", mk(PC_OUT | MAR_IN, 4'h0, 4'h0, 1'b0, 1'b0));

      exec1("sub", 16'h7123, mk(ALU_OUT | RF_IN, 4'h1, 4'h7, 1'b0, 1'b0));
      exec1("jumpn", 16'hB02A, mk(IR_OUT | PC_IN, 4'h0, 4'h0, 1'b0, 1'b0));
      exec1("jumpr", 16'h0203, mk(RF_OUT | PC_IN, 4'h2, 4'h0, 1'b0, 1'b0));
      bus.rx_zero = 1'b1;
      exec1("jeqzn_t", 16'hC400, mk(IR_OUT | PC_IN, 4'h4, 4'h0, 1'b0, 1'b0));
      exec1("jnezn_f", 16'hD400, mk(NONE, 4'h4, 4'h0, 1'b0, 1'b0));
      bus.rx_zero = 1'b0;
      exec1("jeqzn_f", 16'hC400, mk(NONE, 4'h4, 4'h0, 1'b0, 1'b0));
      exec1("jgtzn_t", 16'hE300, mk(IR_OUT | PC_IN, 4'h3, 4'h0, 1'b0, 1'b0));
      bus.rx_neg = 1'b1;
      exec1("jgtzn_f", 16'hE300, mk(NONE, 4'h3, 4'h0, 1'b0, 1'b0));
      exec1("jltzn_t", 16'hF300, mk(IR_OUT | PC_IN, 4'h3, 4'h0, 1'b0, 1'b0));
      bus.rx_neg = 1'b0;

      // loadn r1 with reset landing during EXEC_B
      bus.instr = 16'h2105;
      step();
      step();
      step(); check("loadn_exec_a", mk(IR_OUT | MAR_IN, 4'h1, 4'h0, 1'b0, 1'b0));
      step(); check("loadn_exec_b", mk(RAM_OUT | RF_IN, 4'h1, 4'h0, 1'b0, 1'b0));
      rst = 1'b0;
      step(); check("loadn_reset", mk(NONE, 4'h0, 4'h0, 1'b0, 1'b0));
      rst = 1'b1;
      step(); check("idle_no_run", mk(NONE, 4'h0, 4'h0, 1'b0, 1'b0));

      // halt, then run toggling is ignored
      bus.instr = 16'h0000;
      bus.run = 1'b1;
      step(); check("halt_fetch_a", mk(PC_OUT | MAR_IN, 4'h0, 4'h0, 1'b0, 1'b0));
      bus.run = 1'b0;
      step();
      step();
      step(); check("halt_enter", mk(NONE, 4'h0, 4'h0, 1'b1, 1'b0));
      for (int i = 0; i < 10; i++) begin
         bus.run = i[0];
         step(); check("halt_hold", mk(NONE, 4'h0, 4'h0, 1'b1, 1'b0));
      end
      rst = 1'b0;
      bus.run = 1'b0;
      step(); check("halt_reset", mk(NONE, 4'h0, 4'h0, 1'b0, 1'b0));

      // opc 0100 is illegal
      rst = 1'b1;
      bus.instr = 16'h4120;
      bus.run = 1'b1;
      step();
      bus.run = 1'b0;
      step();
      step();
      step(); check("illegal_4120", mk(NONE, 4'h0, 4'h0, 1'b1, 1'b1));
      bus.run = 1'b1;
      step(); check("illegal_hold", mk(NONE, 4'h0, 4'h0, 1'b1, 1'b1));
      bus.run = 1'b0;
      rst = 1'b0;
      step(); check("illegal_reset", mk(NONE, 4'h0, 4'h0, 1'b0, 1'b0));

      // jumpn with nonzero rx is illegal
      rst = 1'b1;
      bus.instr = 16'hB100;
      bus.run = 1'b1;
      step();
      bus.run = 1'b0;
      step();
      step();
      step(); check("illegal_b100", mk(NONE, 4'h0, 4'h0, 1'b1, 1'b1));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
